// File: rtl/fifo_gen_reader_if.sv
// Handshake bundle for fifo_gen_reader: command port, FWFT FIFO read side and output beat stream.
// master = environment side (drives commands, FIFO head, downstream accept); slave = the reader.
interface fifo_gen_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
);
  logic                  cmd_vld;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  cmd_rdy;
  logic                  done;
  logic                  s_data_vld;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_read;
  logic                  m_data_vld;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_read;

  modport master (
    output cmd_vld, cmd_len, s_data_vld, s_data, m_read,
    input  cmd_rdy, done, s_read, m_data_vld, m_data, m_last
  );

  modport slave (
    input  cmd_vld, cmd_len, s_data_vld, s_data, m_read,
    output cmd_rdy, done, s_read, m_data_vld, m_data, m_last
  );
endinterface

// File: rtl/fifo_gen_reader.sv
// Pops cmd_len beats from an FWFT FIFO into a 2-entry skid buffer feeding a valid/read stream.
// Optional FIFO_GEN_READER_STATS_EN adds stall_cnt (RUN cycles starved by an empty FIFO).
module fifo_gen_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic               clk,
  input  logic               rst,
  fifo_gen_reader_if.slave   bus
`ifdef FIFO_GEN_READER_STATS_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] hd_data, tl_data;
  logic                  hd_last, tl_last;
  logic                  hd_vld, tl_vld;
  logic                  rem_nz, pop, xfer, new_last;

  // Tail is only ever filled behind a valid head, so occupancy<=1 is simply !tl_vld.
  assign rem_nz   = |remaining;
  assign new_last = (remaining == LEN_WIDTH'(1));
  assign pop      = bus.s_read && bus.s_data_vld;
  assign xfer     = hd_vld && bus.m_read;

  // Reset masks the pop so an aborted command never consumes a FIFO word.
  assign bus.s_read     = !rst && (state == RUN) && rem_nz && !tl_vld;
  assign bus.cmd_rdy    = (state == IDLE);
  assign bus.done       = (state == FLUSH) && !hd_vld;
  assign bus.m_data_vld = hd_vld;
  assign bus.m_data     = hd_data;
  assign bus.m_last     = hd_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_vld) begin
          remaining <= bus.cmd_len;
          state     <= (bus.cmd_len != '0) ? RUN : FLUSH;
        end
        RUN: if (pop) begin
          remaining <= remaining - LEN_WIDTH'(1);
          if (new_last) state <= FLUSH;
        end
        FLUSH: if (!hd_vld) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Skid buffer: head drives the outputs, tail absorbs the one pop in flight during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      hd_data <= '0;
      tl_data <= '0;
      hd_last <= 1'b0;
      tl_last <= 1'b0;
      hd_vld  <= 1'b0;
      tl_vld  <= 1'b0;
    end else if (xfer) begin
      if (tl_vld) begin
        hd_data <= tl_data;
        hd_last <= tl_last;
        tl_vld  <= 1'b0;
      end else if (pop) begin
        hd_data <= bus.s_data;
        hd_last <= new_last;
      end else begin
        hd_vld  <= 1'b0;
      end
    end else if (pop) begin
      if (!hd_vld) begin
        hd_data <= bus.s_data;
        hd_last <= new_last;
        hd_vld  <= 1'b1;
      end else begin
        tl_data <= bus.s_data;
        tl_last <= new_last;
        tl_vld  <= 1'b1;
      end
    end
  end

`ifdef FIFO_GEN_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && bus.cmd_vld))
      stall_cnt <= '0;
    else if (state == RUN && rem_nz && !tl_vld && !bus.s_data_vld && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_gen_reader.sv
// Scoreboard bench for fifo_gen_reader: directed commands, FWFT FIFO model, negedge monitor.
module tb_fifo_gen_reader;
  logic clk, rst;
  fifo_gen_reader_if #(.DATA_WIDTH(32), .LEN_WIDTH(16)) ifc ();
`ifdef FIFO_GEN_READER_STATS_EN
  logic [31:0] stall_cnt;
`endif

  fifo_gen_reader #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
`ifdef FIFO_GEN_READER_STATS_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  int tests = 0, fails = 0;
  int cyc = 0;
  logic [31:0] fq[$];
  logic [32:0] exp_q[$];
  int pop_cyc[$], xfer_cyc[$];
  int pops = 0, vld_cnt = 0, done_cnt = 0, exp_done_cyc = -1, acc_cyc = 0;
  logic gate = 1'b1;
  logic pop_now;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task refresh();
    ifc.s_data_vld = (fq.size() > 0) && gate;
    ifc.s_data     = (fq.size() > 0) ? fq[0] : 32'h0;
  endtask

  task step();
    @(posedge clk);
    #2;
  endtask

  // FWFT FIFO model: decide the pop away from the edge, apply it just after.
  initial forever begin
    @(negedge clk);
    pop_now = ifc.s_read && ifc.s_data_vld;
    @(posedge clk);
    #1;
    if (pop_now && fq.size() > 0) void'(fq.pop_front());
    refresh();
  end

  // Monitor / scoreboard
  logic [31:0] held_data;
  logic        held_last, prev_stall = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (ifc.s_read && ifc.s_data_vld) begin
        pops++;
        pop_cyc.push_back(cyc);
      end
      if (ifc.m_data_vld) vld_cnt++;
      if (ifc.m_data_vld && !ifc.m_read) begin
        if (prev_stall) begin
          chk("hold_data", ifc.m_data, held_data);
          chk("hold_last", ifc.m_last, held_last);
        end
        held_data  = ifc.m_data;
        held_last  = ifc.m_last;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (ifc.m_data_vld && ifc.m_read) begin
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("m_data", ifc.m_data, e[31:0]);
          chk("m_last", ifc.m_last, e[32]);
        end
        xfer_cyc.push_back(cyc);
        if (ifc.m_last) exp_done_cyc = cyc + 1;
      end
      if (ifc.done) begin
        done_cnt++;
        chk("done_cycle", cyc, exp_done_cyc);
      end
    end
  end

  task load(input logic [31:0] w, input logic last);
    fq.push_back(w);
    exp_q.push_back({last, w});
    refresh();
  endtask

  task send_cmd(input int len);
    int i;
    ifc.cmd_vld = 1'b1;
    ifc.cmd_len = 16'(len);
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.cmd_rdy) break;
    end
    chk("cmd_accept", ifc.cmd_rdy, 1);
    acc_cyc = cyc;
    if (len == 0) exp_done_cyc = cyc + 1;
    step();
    ifc.cmd_vld = 1'b0;
  endtask

  task wait_done();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
    chk("done_seen", done_cnt - d0, 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    step();
  endtask

  task new_test();
    pop_cyc.delete();
    xfer_cyc.delete();
  endtask

  initial begin
    int p0, v0, d0, fsz;
    rst = 1'b1;
    ifc.cmd_vld = 1'b0;
    ifc.cmd_len = '0;
    ifc.m_read  = 1'b0;
    refresh();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_rdy", ifc.cmd_rdy, 1);
    chk("rst_done", ifc.done, 0);
    chk("rst_s_read", ifc.s_read, 0);
    chk("rst_m_vld", ifc.m_data_vld, 0);
    chk("rst_m_last", ifc.m_last, 0);
    chk("rst_m_data", ifc.m_data, 0);
    step();

    // len=4, streaming at full rate
    new_test();
    ifc.m_read = 1'b1;
    load(32'hA, 0); load(32'hB, 0); load(32'hC, 0); load(32'hD, 1);
    send_cmd(4);
    wait_done();
    chk("t1_pops", pop_cyc.size(), 4);
    chk("t1_first_pop", pop_cyc.size() > 0 ? pop_cyc[0] : -1, acc_cyc + 1);
    for (int i = 1; i < 4 && i < pop_cyc.size(); i++)
      chk("t1_pop_consec", pop_cyc[i], pop_cyc[0] + i);
    for (int i = 0; i < 4 && i < pop_cyc.size() && i < xfer_cyc.size(); i++)
      chk("t1_latency", xfer_cyc[i], pop_cyc[i] + 1);

    // len=3, downstream stalled for 5 cycles
    new_test();
    ifc.m_read = 1'b0;
    load(32'h11, 0); load(32'h22, 0); load(32'h33, 1);
    send_cmd(3);
    repeat (4) step();
    @(negedge clk);
    chk("t2_pops_stalled", pop_cyc.size(), 2);
    chk("t2_s_read_low", ifc.s_read, 0);
    chk("t2_head_vld", ifc.m_data_vld, 1);
    chk("t2_head_word", ifc.m_data, 32'h11);
    step();
    ifc.m_read = 1'b1;
    wait_done();
    chk("t2_pops_total", pop_cyc.size(), 3);

    // len=0 with a word waiting: nothing may pop or emerge
    new_test();
    fq.push_back(32'h55);
    refresh();
    p0 = pops; v0 = vld_cnt;
    send_cmd(0);
    wait_done();
    chk("t3_no_pop", pops - p0, 0);
    chk("t3_no_beat", vld_cnt - v0, 0);
    chk("t3_fifo_kept", fq.size(), 1);
    fq.delete();
    refresh();

    // len=4 with FIFO valid pattern 1,0,1,0,1,1 over the RUN cycles
    new_test();
    load(32'hC0, 0); load(32'hC1, 0); load(32'hC2, 0); load(32'hC3, 1);
    send_cmd(4);
    begin
      logic [5:0] pat;
      pat = 6'b110101;
      for (int i = 0; i < 6; i++) begin
        gate = pat[i];
        refresh();
        step();
      end
    end
    gate = 1'b1;
    refresh();
    wait_done();
    chk("t4_pops", pop_cyc.size(), 4);
`ifdef FIFO_GEN_READER_STATS_EN
    chk("t4_stall_cnt", stall_cnt, 2);
`endif

    // reset mid-command after 2 of 5 beats, then a fresh len=1
    new_test();
    for (int i = 0; i < 5; i++) load(32'hE0 + 32'(i), i == 4);
    d0 = done_cnt;
    send_cmd(5);
    for (int i = 0; i < 50 && xfer_cyc.size() < 2; i++) @(negedge clk);
    chk("t5_pre_reset_beats", xfer_cyc.size() >= 2, 1);
    step();
    rst = 1'b1;
    fsz = fq.size();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_cmd_rdy", ifc.cmd_rdy, 1);
    chk("t5_done", ifc.done, 0);
    chk("t5_s_read", ifc.s_read, 0);
    chk("t5_m_vld", ifc.m_data_vld, 0);
    chk("t5_m_last", ifc.m_last, 0);
    chk("t5_m_data", ifc.m_data, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("t5_fifo_untouched", fq.size(), fsz);
    chk("t5_no_done", done_cnt - d0, 0);
    fq.delete();
    refresh();
    step();
    new_test();
    load(32'h77, 1);
    send_cmd(1);
    wait_done();
    chk("t5_new_pops", pop_cyc.size(), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fifo_gen_reader.md
FIFO_GEN_READER -- requirements
Module: fifo_gen_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the payload width in bits.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, giving the beat-count width of a command.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cmd_vld, input, 1 bit: a read command is offered.
REQ-006 SHALL have port cmd_len, input, LEN_WIDTH bits: number of beats to pop.
REQ-007 SHALL have port cmd_rdy, output, 1 bit: a command is accepted when cmd_vld and cmd_rdy are both high.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port s_data_vld, input, 1 bit: the FWFT FIFO is non-empty.
REQ-010 SHALL have port s_data, input, DATA_WIDTH bits: the FWFT FIFO head word.
REQ-011 SHALL have port s_read, output, 1 bit: pop request to the FWFT FIFO.
REQ-012 SHALL have port m_data_vld, output, 1 bit: an output beat is valid.
REQ-013 SHALL have port m_data, output, DATA_WIDTH bits: output beat.
REQ-014 SHALL have port m_last, output, 1 bit: marks the final beat of a command.
REQ-015 SHALL have port m_read, input, 1 bit: downstream accept; a beat transfers when m_data_vld and m_read are both high.

Function
REQ-016 SHALL implement states IDLE, RUN and FLUSH.
REQ-017 Transitions: IDLE->RUN on command accept with cmd_len>0; IDLE->FLUSH on accept with cmd_len=0; RUN->FLUSH on the pop of the final beat; FLUSH->IDLE when the skid buffer is empty.
REQ-018 cmd_rdy SHALL be high only in IDLE.
REQ-019 On accept, a remaining-beat counter SHALL load cmd_len; it SHALL decrement by 1 on each pop.
REQ-020 A pop SHALL occur when s_read and s_data_vld are both high; s_data is captured in that same cycle (FWFT).
REQ-021 s_read = RUN and remaining>0 and skid occupancy<=1; it SHALL be registered-state-only, with no combinational path from m_read or s_data_vld.
REQ-022 The block SHALL contain a 2-entry skid buffer; the outputs SHALL be driven from its head register.
REQ-023 Latency: a word popped at cycle t SHALL appear on m_data at t+1 when the buffer is empty.
REQ-024 Sustained throughput SHALL be 1 beat per cycle while s_data_vld and m_read are both held high.
REQ-025 m_last SHALL be high only with the beat whose pop decremented remaining from 1 to 0.
REQ-026 While m_data_vld=1 and m_read=0, m_data and m_last SHALL hold stable.
REQ-027 Simultaneous push and transfer at occupancy 1 SHALL leave occupancy at 1 with order preserved.
REQ-028 done SHALL pulse for exactly 1 cycle on the FLUSH->IDLE transition, which occurs when the last beat transfers or when the buffer is already empty.
REQ-029 With cmd_len=0, done SHALL pulse in the cycle after accept, and no pop or output beat SHALL occur.
REQ-030 s_data_vld low in RUN SHALL stall the block without losing count; cmd_vld outside IDLE SHALL be ignored.

Reset
REQ-031 On rst: state=IDLE, remaining=0, occupancy=0, cmd_rdy=1 after reset release, done=0, s_read=0, m_data_vld=0, m_last=0, m_data=0.
REQ-032 Reset mid-command SHALL abort the command without a done pulse; unpopped FIFO words SHALL remain untouched.

Configuration
REQ-033 Macro FIFO_GEN_READER_STATS_EN: when defined, SHALL add output stall_cnt (32 bits), which counts RUN cycles with remaining>0, occupancy<=1 and s_data_vld=0.
REQ-034 stall_cnt SHALL clear on rst and on command accept, and SHALL saturate at all-ones.
REQ-035 When the macro is undefined, the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 cmd_len=4, FIFO holding A,B,C,D, m_read=1 -> pops in 4 consecutive cycles; m_data A..D on cycles t+1..t+4; m_last with D only; done 1 cycle after D transfers.
REQ-037 cmd_len=3, m_read=0 for 5 cycles then 1 -> exactly 2 pops then s_read=0; m_data holds word 1; all 3 beats delivered in order afterwards.
REQ-038 cmd_len=0 -> done pulses at accept+1; s_read and m_data_vld stay 0.
REQ-039 cmd_len=4, s_data_vld toggling 1,0,1,0 -> 4 pops total, 4 beats in order, with STATS_EN stall_cnt=2 at completion.
REQ-040 rst asserted after 2 of 5 beats -> all outputs at reset values next cycle, no done; a new cmd_len=1 then completes normally.
